ins_fetch_unit: RTL and testbench
=================================

INS_FETCH_UNIT -- requirements
Module: ins_fetch_unit

Interface
REQ-001 The block SHALL have parameter IMEM_AW, default 5, meaning the instruction-memory address width (2^IMEM_AW words of 16 bits).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of prefetch-queue entries (power of two, at least 2).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port load_en, input, 1 bit: instruction-memory write strobe.
REQ-006 The block SHALL have port load_addr, input, IMEM_AW bits: write address.
REQ-007 The block SHALL have port load_data, input, 16 bits: write data.
REQ-008 The block SHALL have port run, input, 1 bit: fetch enable.
REQ-009 The block SHALL have port redirect, input, 1 bit: jump request.
REQ-010 The block SHALL have port redirect_pc, input, IMEM_AW bits: jump target.
REQ-011 The block SHALL have port ins, output, 16 bits: head instruction, {opcode[15:12], rs[11:8], rt[7:4], rd[3:0]}, to the ALU/register-bank stage.
REQ-012 The block SHALL have port ins_valid, output, 1 bit: ins is valid.
REQ-013 The block SHALL have port ins_ready, input, 1 bit: the consumer accepts ins.
REQ-014 The block SHALL have port ins_pc, output, IMEM_AW bits: address of the head instruction.
REQ-015 The block SHALL have port fifo_count, output, log2(FIFO_DEPTH)+1 bits: number of queued entries.
REQ-016 The block SHALL have port halted, output, 1 bit: a HALT word has been fetched.

Function
REQ-017 The instruction memory SHALL be written synchronously at load_addr when load_en=1 and read combinationally at pc.
REQ-018 The FSM SHALL have the states IDLE, FETCH and HALT.
REQ-019 The FSM SHALL make these transitions: IDLE->FETCH when run=1; FETCH->IDLE when run=0; FETCH->HALT on a HALT fetch; HALT->IDLE on redirect.
REQ-020 A fetch SHALL occur in a cycle when state=FETCH, run=1, load_en=0, redirect=0, and either fifo_count<FIFO_DEPTH or a transfer occurs that cycle.
REQ-021 A fetch of a word other than 16'hFFFF SHALL enqueue {pc, mem[pc]} and set pc<=pc+1, wrapping modulo 2^IMEM_AW (last address -> 0).
REQ-022 A fetch of 16'hFFFF SHALL not enqueue, SHALL hold pc at that address, SHALL set halted=1 and SHALL enter HALT.
REQ-023 A transfer SHALL occur when ins_valid=1 and ins_ready=1 on a clock edge; it dequeues the head.
REQ-024 ins_valid SHALL equal (fifo_count!=0); ins and ins_pc SHALL be driven from queue registers, never directly from memory.
REQ-025 An instruction fetched in cycle N SHALL be visible on ins from cycle N+1 when the queue was empty (latency 1).
REQ-026 With a full queue, a simultaneous fetch and transfer SHALL keep fifo_count unchanged with order preserved.
REQ-027 While ins_ready=0, ins, ins_pc and ins_valid SHALL hold stable.
REQ-028 Redirect SHALL have priority over all else: a transfer in the redirect cycle completes, then the queue flushes (fifo_count=0, ins_valid=0 next cycle), pc<=redirect_pc and halted<=0.
REQ-029 Queued entries SHALL drain normally in the IDLE and HALT states.
REQ-030 load_en=1 SHALL suppress fetching that cycle; a write to an address already queued SHALL NOT alter the queued copy.

Reset
REQ-031 reset_n=0 SHALL immediately force state=IDLE, pc=0, fifo_count=0, ins_valid=0, ins=16'h0000, ins_pc=0 and halted=0.
REQ-032 Reset SHALL NOT clear memory contents.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries.
REQ-034 After reset_n deasserts, the first fetch SHALL occur no earlier than the first rising edge with run=1.

Verification
REQ-035 Load mem[0..2]=16'h0123,16'h1456,16'h2789; run=1; ins_ready=1 -> ins shows 0123,1456,2789 on consecutive cycles with ins_pc 0,1,2.
REQ-036 ins_ready=0 with run=1 -> fifo_count saturates at 4, ins stays 16'h0123, pc stops at 4.
REQ-037 A full queue, then ins_ready=1 -> one transfer per cycle with no gaps or duplicates.
REQ-038 mem[3]=16'hFFFF -> three instructions delivered, halted=1, pc=3; then redirect with redirect_pc=0 -> halted=0 and fetching resumes at 0.
REQ-039 Redirect with redirect_pc=31 while 3 entries are queued -> the queue empties next cycle, the next ins_pc is 31, then 0 (wrap).
REQ-040 reset_n=0 mid-stream -> ins_valid=0 and fifo_count=0 immediately; after release, memory is intact and fetching restarts at 0.

Source files
------------

// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit: a loadable instruction memory, a fetch FSM and a
// prefetch queue that hands {pc, instruction} pairs to the next stage.
module ins_fetch_unit #(
    parameter int IMEM_AW    = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          load_en,
    input  logic [IMEM_AW-1:0]            load_addr,
    input  logic [15:0]                   load_data,
    input  logic                          run,
    input  logic                          redirect,
    input  logic [IMEM_AW-1:0]            redirect_pc,
    output logic [15:0]                   ins,
    output logic                          ins_valid,
    input  logic                          ins_ready,
    output logic [IMEM_AW-1:0]            ins_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          halted,
    output logic [1:0]                    state_dbg
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int QW = IMEM_AW + 16;
    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Handshake: a transfer happens on a rising edge where ins_valid and
    // ins_ready are both 1; while ins_ready is 0 the head is held stable.
    state_t              state_q, state_d;
    logic [15:0]         mem [2**IMEM_AW];
    logic [IMEM_AW-1:0]  pc_q;
    logic                halted_q;
    logic [QW-1:0]       q_mem [FIFO_DEPTH];
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [CW-1:0]       count_q;
    logic [15:0]         mem_word;
    logic                xfer, fetch, halt_fetch, push;

    // Memory is intentionally outside the reset domain so programs survive reset.
    always_ff @(posedge clock) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    assign mem_word   = mem[pc_q];
    assign ins_valid  = (count_q != '0);
    assign xfer       = ins_valid && ins_ready;
    assign fetch      = (state_q == ST_FETCH) && run && !load_en && !redirect &&
                        ((count_q < CW'(FIFO_DEPTH)) || xfer);
    assign halt_fetch = fetch && (mem_word == HALT_WORD);
    assign push       = fetch && !halt_fetch;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (halt_fetch) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT:  if (redirect) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else if (redirect) begin
            pc_q     <= redirect_pc;
            halted_q <= 1'b0;
        end else if (push) begin
            pc_q     <= pc_q + 1'b1;
        end else if (halt_fetch) begin
            halted_q <= 1'b1;
        end
    end

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_mem[i] <= '0;
            end
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (redirect) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                q_mem[wr_ptr] <= {pc_q, mem_word};
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (xfer) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, xfer})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign ins        = q_mem[rd_ptr][15:0];
    assign ins_pc     = q_mem[rd_ptr][QW-1:16];
    assign fifo_count = count_q;
    assign halted     = halted_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Bench for ins_fetch_unit: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_ins_fetch_unit;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int W     = AW + 16;
    localparam int MEM_N = 1 << AW;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              load_en;
    logic [AW-1:0]     load_addr;
    logic [15:0]       load_data;
    logic              run;
    logic              redirect;
    logic [AW-1:0]     redirect_pc;
    logic [15:0]       ins;
    logic              ins_valid;
    logic              ins_ready;
    logic [AW-1:0]     ins_pc;
    logic [2:0]        fifo_count;
    logic              halted;
    logic [1:0]        state_dbg;

    ins_fetch_unit #(.IMEM_AW(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .run(run), .redirect(redirect), .redirect_pc(redirect_pc),
        .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_pc(ins_pc),
        .fifo_count(fifo_count), .halted(halted), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: memory image, expected queue of {pc, word}, pc and mode flags.
    logic [15:0]   ref_mem [MEM_N];
    logic [W-1:0]  exp_q [$];
    logic [AW-1:0] m_pc;
    bit            m_fetching;
    bit            m_halted;
    logic [W-1:0]  xfer_log [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] head;
        check("ins_valid", {31'd0, ins_valid}, {31'd0, exp_q.size() != 0});
        check("fifo_count", {29'd0, fifo_count}, exp_q.size());
        check("halted", {31'd0, halted}, {31'd0, m_halted});
        check("state", {30'd0, state_dbg}, m_halted ? 32'd2 : (m_fetching ? 32'd1 : 32'd0));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("ins", {16'd0, ins}, {16'd0, head[15:0]});
            check("ins_pc", {27'd0, ins_pc}, {27'd0, head[W-1:16]});
        end
    endtask

    task automatic model_edge();
        logic [15:0] word;
        bit xfer, fetch, was_h;
        word  = ref_mem[m_pc];
        was_h = m_halted;
        xfer  = (exp_q.size() != 0) && ins_ready;
        fetch = m_fetching && !m_halted && run && !load_en && !redirect &&
                ((exp_q.size() < DEPTH) || xfer);
        if (xfer) void'(exp_q.pop_front());
        if (redirect) begin
            exp_q.delete();
            m_pc       = redirect_pc;
            m_halted   = 1'b0;
            m_fetching = was_h ? 1'b0 : run;
        end else if (was_h) begin
            m_fetching = 1'b0;
        end else if (!run) begin
            m_fetching = 1'b0;
        end else if (fetch && word == 16'hFFFF) begin
            m_fetching = 1'b0;
            m_halted   = 1'b1;
        end else begin
            m_fetching = 1'b1;
            if (fetch) begin
                exp_q.push_back({m_pc, word});
                m_pc = m_pc + 1'b1;
            end
        end
        if (load_en) ref_mem[load_addr] = load_data;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc       = '0;
        m_fetching = 1'b0;
        m_halted   = 1'b0;
    endtask

    task automatic cycle();
        @(negedge clock);
        check_outputs();
        if (ins_valid && ins_ready) xfer_log.push_back({ins_pc, ins});
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        cycle();
        load_en   = 1'b0;
    endtask

    task automatic do_redirect(input logic [AW-1:0] a);
        redirect    = 1'b1;
        redirect_pc = a;
        cycle();
        redirect    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, ins_valid}, 32'd0);
        check({tag, "_count"}, {29'd0, fifo_count}, 32'd0);
        check({tag, "_ins"}, {16'd0, ins}, 32'd0);
        check({tag, "_pc"}, {27'd0, ins_pc}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
        check({tag, "_state"}, {30'd0, state_dbg}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        run = 1'b0; redirect = 1'b0; redirect_pc = '0; ins_ready = 1'b0;
        model_reset();
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Program image: a known prefix, then random non-halt words.
        load_word(5'd0, 16'h0123);
        load_word(5'd1, 16'h1456);
        load_word(5'd2, 16'h2789);
        load_word(5'd3, 16'h3abc);
        for (int i = 4; i < MEM_N; i++) load_word(AW'(i), 16'($urandom_range(0, 16'hFFFE)));

        // Streaming with a ready consumer.
        xfer_log.delete();
        ins_ready = 1'b1; run = 1'b1;
        run_cycles(6);
        run = 1'b0;
        run_cycles(6);
        check("stream0", xfer_log[0], {5'd0, 16'h0123});
        check("stream1", xfer_log[1], {5'd1, 16'h1456});
        check("stream2", xfer_log[2], {5'd2, 16'h2789});

        // Back-pressure fills the queue, then it drains one per cycle.
        do_redirect(5'd0);
        ins_ready = 1'b0; run = 1'b1;
        run_cycles(8);
        check("full_count", {29'd0, fifo_count}, 32'd4);
        check("full_ins", {16'd0, ins}, 32'h0123);
        xfer_log.delete();
        run = 1'b0; ins_ready = 1'b1;
        run_cycles(4);
        check("drain_n", xfer_log.size(), 32'd4);
        check("drain0", xfer_log[0], {5'd0, 16'h0123});
        check("drain1", xfer_log[1], {5'd1, 16'h1456});
        check("drain2", xfer_log[2], {5'd2, 16'h2789});
        check("drain3", xfer_log[3], {5'd3, 16'h3abc});
        // The pc stopped at 4: the next fetch after resuming comes from address 4.
        xfer_log.delete();
        run = 1'b1;
        run_cycles(3);
        check("resume4", {27'd0, xfer_log[0][W-1:16]}, 32'd4);
        run = 1'b0;
        run_cycles(6);

        // HALT word at address 3, then release by redirect.
        load_word(5'd3, 16'hFFFF);
        do_redirect(5'd0);
        xfer_log.delete();
        run = 1'b1;
        run_cycles(10);
        check("halt_n", xfer_log.size(), 32'd3);
        check("halt_flag", {31'd0, halted}, 32'd1);
        xfer_log.delete();
        do_redirect(5'd0);
        check("unhalt", {31'd0, halted}, 32'd0);
        run_cycles(3);
        check("unhalt_pc0", xfer_log[0], {5'd0, 16'h0123});
        run = 1'b0;
        run_cycles(6);
        load_word(5'd3, 16'h3abc);

        // Redirect to the last address with three entries queued.
        do_redirect(5'd0);
        ins_ready = 1'b0; run = 1'b1;
        run_cycles(4);
        check("pre_redir_count", {29'd0, fifo_count}, 32'd3);
        ins_ready = 1'b1;
        do_redirect(5'd31);
        check("redir_flush", {29'd0, fifo_count}, 32'd0);
        xfer_log.delete();
        run_cycles(4);
        check("wrap31", {27'd0, xfer_log[0][W-1:16]}, 32'd31);
        check("wrap0", {27'd0, xfer_log[1][W-1:16]}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            run       = ($urandom_range(0, 9) < 8);
            ins_ready = $urandom_range(0, 1) == 1;
            load_en   = ($urandom_range(0, 15) == 0);
            load_addr = AW'($urandom_range(0, MEM_N - 1));
            load_data = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
            redirect  = halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
            redirect_pc = AW'($urandom_range(0, MEM_N - 1));
            cycle();
        end
        load_en = 1'b0; redirect = 1'b0; run = 1'b0;

        // Reset in the middle of a stream.
        load_word(5'd0, 16'h0123);
        do_redirect(5'd0);
        ins_ready = 1'b0; run = 1'b1;
        run_cycles(4);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("midrst");
        run = 1'b0; ins_ready = 1'b0;
        model_reset();
        @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock);
        #1;
        xfer_log.delete();
        ins_ready = 1'b1; run = 1'b1;
        run_cycles(8);
        check("restart0", xfer_log[0], {5'd0, 16'h0123});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
